// File: rtl/mmio_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: FSM states,
// register offsets and STATUS bit positions.
package mmio_uart_tx_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } uart_state_e;

  localparam logic [31:0] TXDATA_OFS = 32'h0000_0000;
  localparam logic [31:0] STATUS_OFS = 32'h0000_0004;

  localparam int STATUS_FULL_BIT = 0;
  localparam int STATUS_BUSY_BIT = 1;
  localparam int STATUS_OVF_BIT  = 2;
  localparam int STATUS_PAR_BIT  = 3;

`ifdef UART_PARITY_EN
  localparam logic PARITY_EN = 1'b1;
`else
  localparam logic PARITY_EN = 1'b0;
`endif

  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/mmio_uart_tx_if.sv
// Data-bus view of the UART: the core drives stores/addresses (master),
// the UART answers with combinational read data (slave).
interface mmio_uart_tx_if;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic [31:0] read_data;

  modport master (output mem_write, output addr, output write_data, input read_data);
  modport slave  (input mem_write, input addr, input write_data, output read_data);
endinterface

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Small synchronous FIFO with first-word fall-through read data; a push into
// a full FIFO is only taken when a pop frees a slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter (8N1; 8E1 when UART_PARITY_EN is defined).
// Stores to TXDATA queue a byte, STATUS reports {PAR, overflow, busy, full}.
module mmio_uart_tx
  import mmio_uart_tx_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic            clk,
  input  logic            reset,
  mmio_uart_tx_if.slave   bus,
  output logic            tx,
  output logic            busy
);
  localparam int                BW          = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0]     BAUD_LAST   = BW'(CLKS_PER_BIT - 1);
  localparam logic [31:0]       TXDATA_ADDR = BASE_ADDR + TXDATA_OFS;
  localparam logic [31:0]       STATUS_ADDR = BASE_ADDR + STATUS_OFS;

  uart_state_e   state, state_d;
  logic [BW-1:0] baud, baud_d;
  logic [2:0]    bit_idx, bit_d;
  logic [7:0]    shift, shift_d;
  logic          tx_d;
  logic          busy_d;
  logic          overflow;
  logic          pop;
  logic          bit_end;
  logic          wr_tx;
  logic          wr_status;
  logic          push_ok;
  logic          fifo_full;
  logic          fifo_empty;
  logic [7:0]    fifo_data;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic          unused_bits;
`ifdef UART_PARITY_EN
  logic          par_bit, par_d;
`endif

  assign unused_bits = ^bus.write_data[31:8];
  assign wr_tx       = bus.mem_write && (bus.addr == TXDATA_ADDR);
  assign wr_status   = bus.mem_write && (bus.addr == STATUS_ADDR);
  assign push_ok     = wr_tx && (!fifo_full || pop);
  assign bit_end     = (baud == BAUD_LAST);

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (wr_tx),
    .pop     (pop),
    .wr_data (bus.write_data[7:0]),
    .rd_data (fifo_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_comb begin
    bus.read_data = '0;
    if (bus.addr == STATUS_ADDR) begin
      bus.read_data[STATUS_FULL_BIT] = fifo_full;
      bus.read_data[STATUS_BUSY_BIT] = busy;
      bus.read_data[STATUS_OVF_BIT]  = overflow;
      bus.read_data[STATUS_PAR_BIT]  = PARITY_EN;
    end
  end

  // Next-state logic: a pop reloads the shifter and starts a frame at once,
  // so back-to-back frames leave no idle bit between STOP and START.
  always_comb begin
    state_d = state;
    baud_d  = baud;
    bit_d   = bit_idx;
    shift_d = shift;
    tx_d    = tx;
    pop     = 1'b0;
`ifdef UART_PARITY_EN
    par_d   = par_bit;
`endif
    if (state != S_IDLE) baud_d = bit_end ? '0 : baud + 1'b1;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = S_START;
          shift_d = fifo_data;
          baud_d  = '0;
          tx_d    = 1'b0;
`ifdef UART_PARITY_EN
          par_d   = even_parity(fifo_data);
`endif
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          tx_d    = shift[0];
          shift_d = shift >> 1;
          bit_d   = 3'd0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
            state_d = S_PARITY;
            tx_d    = par_bit;
`else
            state_d = S_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            tx_d    = shift[0];
            shift_d = shift >> 1;
            bit_d   = bit_idx + 3'd1;
          end
        end
      end
`ifdef UART_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = S_START;
            shift_d = fifo_data;
            tx_d    = 1'b0;
`ifdef UART_PARITY_EN
            par_d   = even_parity(fifo_data);
`endif
          end else begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
    busy_d = (state_d != S_IDLE) || (fifo_count != '0) || push_ok;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      baud     <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      overflow <= 1'b0;
`ifdef UART_PARITY_EN
      par_bit  <= 1'b0;
`endif
    end else begin
      state    <= state_d;
      baud     <= baud_d;
      bit_idx  <= bit_d;
      shift    <= shift_d;
      tx       <= tx_d;
      busy     <= busy_d;
`ifdef UART_PARITY_EN
      par_bit  <= par_d;
`endif
      if (wr_status) overflow <= 1'b0;
      else if (wr_tx && fifo_full && !pop) overflow <= 1'b1;
    end
  end
endmodule
